// File: rtl/wallace_mult_if.sv
// ---------------------------------------------------------------------------
// wallace_mult_if
// Bundles both valid/ready channels of the pipelined multiplier.
//   in_valid / in_ready     : operand handshake
//   in_a / in_b             : WIDTH-bit operands
//   in_signed               : 1 = two's complement operands, 0 = unsigned
//   in_tag                  : sideband tag travelling with the operation
//   out_valid / out_ready   : product handshake
//   out_prod                : 2*WIDTH-bit product
//   out_tag                 : tag of the operation that produced out_prod
// master: the producer/consumer around the multiplier (drives operands and
//         out_ready); slave: the multiplier itself.
// ---------------------------------------------------------------------------
interface wallace_mult_if #(
    parameter int WIDTH = 8,
    parameter int TAG_W = 4
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     in_a;
    logic [WIDTH-1:0]     in_b;
    logic                 in_signed;
    logic [TAG_W-1:0]     in_tag;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   out_prod;
    logic [TAG_W-1:0]     out_tag;

    modport master (
        output in_valid, in_a, in_b, in_signed, in_tag, out_ready,
        input  in_ready, out_valid, out_prod, out_tag
    );

    modport slave (
        input  in_valid, in_a, in_b, in_signed, in_tag, out_ready,
        output in_ready, out_valid, out_prod, out_tag
    );
endinterface

// File: rtl/wallace_mult_pipe.sv
// ---------------------------------------------------------------------------
// wallace_mult_pipe
// Three-stage pipelined Wallace-tree multiplier, WIDTH x WIDTH -> 2*WIDTH,
// unsigned or two's complement selected per operation.
//   Stage 1: partial-product generation (registered)
//   Stage 2: carry-save tree reduction down to two rows (registered)
//   Stage 3: final carry-propagate add (registered, drives the output)
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous reset, active high
//   bus  : wallace_mult_if.slave (operand and product valid/ready channels)
// The whole pipe advances together whenever the output register is empty
// or being drained, so in_ready depends only on out_valid/out_ready.
// ---------------------------------------------------------------------------
module wallace_mult_pipe #(
    parameter int WIDTH = 8,
    parameter int TAG_W = 4
) (
    input  logic           clk,
    input  logic           rst,
    wallace_mult_if.slave  bus
);
    localparam int PW = 2 * WIDTH;
    // WIDTH+1 Baugh-Wooley rows plus one row carrying the correction constant
    localparam int NR = WIDTH + 2;
    // Scratch headroom so group indexing inside the tree never leaves the array
    localparam int NA = NR + 3;

    logic adv;

    logic               v1, v2, v3;
    logic [TAG_W-1:0]   t1, t2, t3;
    logic [PW-1:0]      pp_d [NR];
    logic [PW-1:0]      pp_q [NR];
    logic [PW-1:0]      sum_d, carry_d;
    logic [PW-1:0]      sum_q, carry_q;
    logic [PW-1:0]      prod_q;

    logic [WIDTH:0]     a_ext, b_ext;

    assign adv          = ~v3 | bus.out_ready;
    assign bus.in_ready = adv;

    // Operands are widened by one bit (sign-extended when signed, zero when
    // unsigned); a single (WIDTH+1)-bit signed Baugh-Wooley array then covers
    // both modes. The exact product fits in 2*WIDTH bits either way, so the
    // result modulo 2^(2*WIDTH) is the true product.
    assign a_ext = {bus.in_signed & bus.in_a[WIDTH-1], bus.in_a};
    assign b_ext = {bus.in_signed & bus.in_b[WIDTH-1], bus.in_b};

    // Baugh-Wooley partial products: terms pairing exactly one sign bit are
    // inverted, and the constant 2^(WIDTH+1) compensates (the companion
    // constant 2^(2*WIDTH+1) falls outside the product width).
    always_comb begin
        logic [PW+1:0] row;
        logic          bit_v;
        for (int i = 0; i < NR; i++) begin
            pp_d[i] = '0;
        end
        for (int i = 0; i <= WIDTH; i++) begin
            row = '0;
            for (int j = 0; j <= WIDTH; j++) begin
                bit_v = a_ext[j] & b_ext[i];
                if ((i == WIDTH) != (j == WIDTH)) begin
                    bit_v = ~bit_v;
                end
                row[i+j] = bit_v;
            end
            pp_d[i] = row[PW-1:0];
        end
        pp_d[NR-1][WIDTH+1] = 1'b1;
    end

    // Wallace reduction on whole rows: each layer feeds rows in groups of
    // three through 3:2 counters, leftover rows pass to the next layer, and
    // layers repeat until only a sum row and a carry row remain.
    function automatic logic [2*PW-1:0] reduce_rows(input logic [PW-1:0] rows_in [NR]);
        logic [PW-1:0] cur [NA];
        logic [PW-1:0] nxt [NA];
        int            cnt;
        int            ncnt;
        cur = '{default: '0};
        nxt = '{default: '0};
        for (int k = 0; k < NR; k++) begin
            cur[k] = rows_in[k];
        end
        cnt = NR;
        for (int l = 0; l < NR; l++) begin
            if (cnt > 2) begin
                nxt  = '{default: '0};
                ncnt = 0;
                for (int i = 0; i < NR; i += 3) begin
                    if (i + 2 < cnt) begin
                        nxt[ncnt]   = cur[i] ^ cur[i+1] ^ cur[i+2];
                        nxt[ncnt+1] = ((cur[i] & cur[i+1]) | (cur[i] & cur[i+2]) |
                                       (cur[i+1] & cur[i+2])) << 1;
                        ncnt += 2;
                    end else if (i < cnt) begin
                        nxt[ncnt] = cur[i];
                        ncnt += 1;
                        if (i + 1 < cnt) begin
                            nxt[ncnt] = cur[i+1];
                            ncnt += 1;
                        end
                    end
                end
                cur = nxt;
                cnt = ncnt;
            end
        end
        return {cur[0], cur[1]};
    endfunction

    assign {sum_d, carry_d} = reduce_rows(pp_q);

    // Stage registers. Data is cleared on reset so out_prod never shows X,
    // and every stage only moves when the global advance is asserted.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1      <= 1'b0;
            v2      <= 1'b0;
            v3      <= 1'b0;
            t1      <= '0;
            t2      <= '0;
            t3      <= '0;
            pp_q    <= '{default: '0};
            sum_q   <= '0;
            carry_q <= '0;
            prod_q  <= '0;
        end else if (adv) begin
            v1      <= bus.in_valid;
            t1      <= bus.in_tag;
            pp_q    <= pp_d;
            v2      <= v1;
            t2      <= t1;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            v3      <= v2;
            t3      <= t2;
            prod_q  <= sum_q + carry_q;
        end
    end

    assign bus.out_valid = v3;
    assign bus.out_prod  = prod_q;
    assign bus.out_tag   = t3;

endmodule

// File: tb/tb_wallace_mult_pipe.sv
// ---------------------------------------------------------------------------
// tb_wallace_mult_pipe
// Self-checking bench for wallace_mult_pipe (WIDTH=8, TAG_W=4): a table of
// corner-case products with latency checks, then streaming, backpressure,
// random valid/ready traffic and reset in mid-operation. A negedge monitor
// keeps a queue of expected {product, tag} built from plain integer
// arithmetic and compares every output handshake against it.
// ---------------------------------------------------------------------------
module tb_wallace_mult_pipe;
    localparam int WIDTH = 8;
    localparam int TAG_W = 4;
    localparam int PW    = 2 * WIDTH;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    wallace_mult_if #(.WIDTH(WIDTH), .TAG_W(TAG_W)) mif ();

    wallace_mult_pipe #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (mif)
    );

    typedef struct {
        logic [PW-1:0]    prod;
        logic [TAG_W-1:0] tag;
    } exp_t;

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             s;
        logic [PW-1:0]    prod;
    } vec_t;

    int   errors = 0;
    int   checks = 0;
    int   popped = 0;
    exp_t sb_q[$];

    logic             hold_pending = 1'b0;
    logic [PW-1:0]    hold_prod;
    logic [TAG_W-1:0] hold_tag;

    // Reference: exact integer product with operands read as signed or
    // unsigned, reduced to 2*WIDTH bits.
    function automatic logic [PW-1:0] refMul(input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b,
                                             input logic s);
        int x, y, p;
        x = s ? int'($signed(a)) : int'(a);
        y = s ? int'($signed(b)) : int'(b);
        p = x * y;
        return p[PW-1:0];
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act,
                               input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic randomOp();
        mif.in_a      = WIDTH'($urandom());
        mif.in_b      = WIDTH'($urandom());
        mif.in_signed = 1'($urandom());
        mif.in_tag    = TAG_W'($urandom());
    endtask

    // Single-op driver used by the corner-case table: present one op, then
    // count edges until the product appears (bounded).
    task automatic applyStimulus(input vec_t v, input logic [TAG_W-1:0] tag, output int lat);
        mif.in_valid  = 1'b1;
        mif.in_a      = v.a;
        mif.in_b      = v.b;
        mif.in_signed = v.s;
        mif.in_tag    = tag;
        mif.out_ready = 1'b1;
        @(posedge clk);
        #1;
        mif.in_valid = 1'b0;
        lat = 1;
        while (!mif.out_valid && lat < 10) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic drain();
        int n;
        mif.in_valid  = 1'b0;
        mif.out_ready = 1'b1;
        n = 0;
        while ((sb_q.size() != 0 || mif.out_valid) && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("drain_queue_empty", 64'(sb_q.size()), 64'd0);
    endtask

    // Monitor: sample handshakes mid-cycle, keep the scoreboard, and check
    // that a stalled output stays put.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                sb_q.delete();
                hold_pending = 1'b0;
            end else begin
                if (hold_pending) begin
                    checkOutput("stall_out_valid", 64'(mif.out_valid), 64'd1);
                    checkOutput("stall_out_prod", 64'(mif.out_prod), 64'(hold_prod));
                    checkOutput("stall_out_tag", 64'(mif.out_tag), 64'(hold_tag));
                end
                hold_pending = mif.out_valid && !mif.out_ready;
                hold_prod    = mif.out_prod;
                hold_tag     = mif.out_tag;
                if (mif.out_valid && mif.out_ready) begin
                    if (sb_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL unexpected_output: got prod 0x%0h tag %0h, expected none",
                                 mif.out_prod, mif.out_tag);
                    end else begin
                        exp_t e;
                        e = sb_q.pop_front();
                        popped++;
                        checkOutput("sb_prod", 64'(mif.out_prod), 64'(e.prod));
                        checkOutput("sb_tag", 64'(mif.out_tag), 64'(e.tag));
                    end
                end
                if (mif.in_valid && mif.in_ready) begin
                    exp_t e;
                    e.prod = refMul(mif.in_a, mif.in_b, mif.in_signed);
                    e.tag  = mif.in_tag;
                    sb_q.push_back(e);
                end
            end
        end
    end

    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        vec_t vecs[9];
        int   lat;
        int   cnt;
        int   sent;
        int   cyc;
        logic acc;

        vecs[0] = '{a: 8'hFF, b: 8'hFF, s: 1'b0, prod: 16'hFE01};
        vecs[1] = '{a: 8'h00, b: 8'hA5, s: 1'b0, prod: 16'h0000};
        vecs[2] = '{a: 8'hFF, b: 8'hFF, s: 1'b1, prod: 16'h0001};
        vecs[3] = '{a: 8'h80, b: 8'h80, s: 1'b1, prod: 16'h4000};
        vecs[4] = '{a: 8'h7F, b: 8'h80, s: 1'b1, prod: 16'hC080};
        vecs[5] = '{a: 8'h80, b: 8'h01, s: 1'b1, prod: 16'hFF80};
        vecs[6] = '{a: 8'h7F, b: 8'h7F, s: 1'b1, prod: 16'h3F01};
        vecs[7] = '{a: 8'h80, b: 8'hFF, s: 1'b0, prod: 16'h7F80};
        vecs[8] = '{a: 8'h80, b: 8'hFF, s: 1'b1, prod: 16'h0080};

        rst           = 1'b1;
        mif.in_valid  = 1'b0;
        mif.in_a      = '0;
        mif.in_b      = '0;
        mif.in_signed = 1'b0;
        mif.in_tag    = '0;
        mif.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_out_valid", 64'(mif.out_valid), 64'd0);
        checkOutput("reset_out_prod", 64'(mif.out_prod), 64'd0);
        checkOutput("reset_out_tag", 64'(mif.out_tag), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("reset_in_ready", 64'(mif.in_ready), 64'd1);
        @(posedge clk);
        #1;

        $display("[TB] corner-case table");
        for (int i = 0; i < 9; i++) begin
            applyStimulus(vecs[i], TAG_W'(i + 3), lat);
            checkOutput($sformatf("table%0d_prod", i), 64'(mif.out_prod), 64'(vecs[i].prod));
            checkOutput($sformatf("table%0d_tag", i), 64'(mif.out_tag), 64'(i + 3));
            checkOutput($sformatf("table%0d_latency", i), 64'(lat), 64'd3);
        end
        drain();
        repeat (3) @(posedge clk);
        #1;

        $display("[TB] streaming 256 ops");
        cnt = 0;
        popped = 0;
        for (int n = 0; n < 258; n++) begin
            if (n < 256) begin
                mif.in_valid = 1'b1;
                randomOp();
            end else begin
                mif.in_valid = 1'b0;
            end
            @(posedge clk);
            #1;
            if (mif.out_valid) cnt++;
        end
        checkOutput("stream_valid_cycles", 64'(cnt), 64'd256);
        drain();
        checkOutput("stream_results", 64'(popped), 64'd256);

        $display("[TB] backpressure");
        popped = 0;
        sent = 0;
        mif.in_valid = 1'b1;
        randomOp();
        for (int c = 0; c < 30; c++) begin
            mif.out_ready = !(c >= 10 && c < 15);
            @(negedge clk);
            if (c >= 10 && c < 15) begin
                checkOutput("bp_in_ready_low", 64'(mif.in_ready), 64'd0);
            end
            acc = mif.in_valid && mif.in_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                sent++;
                randomOp();
            end
        end
        drain();
        checkOutput("bp_no_loss", 64'(popped), 64'(sent));

        $display("[TB] random valid/ready traffic");
        popped = 0;
        sent = 0;
        cyc = 0;
        mif.in_valid = 1'b0;
        randomOp();
        while (sent < 10000 && cyc < 60000) begin
            if (!mif.in_valid) begin
                mif.in_valid = ($urandom_range(0, 3) != 0);
            end
            mif.out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            acc = mif.in_valid && mif.in_ready;
            @(posedge clk);
            #1;
            cyc++;
            if (acc) begin
                sent++;
                randomOp();
                mif.in_valid = ($urandom_range(0, 3) != 0);
            end
        end
        checkOutput("random_all_sent", 64'(sent), 64'd10000);
        drain();
        checkOutput("random_no_loss", 64'(popped), 64'(sent));

        $display("[TB] reset mid-operation");
        popped = 0;
        mif.out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            mif.in_valid = 1'b1;
            randomOp();
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        randomOp();
        @(posedge clk);
        #1;
        checkOutput("midreset_out_valid", 64'(mif.out_valid), 64'd0);
        checkOutput("midreset_out_prod", 64'(mif.out_prod), 64'd0);
        checkOutput("midreset_out_tag", 64'(mif.out_tag), 64'd0);
        rst = 1'b0;
        mif.in_valid = 1'b0;
        mif.out_ready = 1'b1;
        @(negedge clk);
        checkOutput("midreset_in_ready", 64'(mif.in_ready), 64'd1);
        cnt = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            if (mif.out_valid) cnt++;
        end
        checkOutput("midreset_nothing_emerges", 64'(cnt), 64'd0);
        checkOutput("midreset_no_pops", 64'(popped), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
